mips_fetch_unit: RTL and testbench
==================================

// Module: mips_fetch_unit
// PURPOSE
//  Instruction-fetch front end for mips_32: owns the PC, issues word reads to instruction memory,
//  buffers returned instructions in a small in-order prefetch FIFO and hands them to the datapath.
//  Sits directly upstream of the datapath. Redirects (taken branch/jump) come back from the datapath
//  and flush all buffered and in-flight fetches.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC fetched first after reset
//  FIFO_DEPTH   4              prefetch entries (power of 2, >=2)
//  MAX_OUTST    2              max imem requests in flight (1..FIFO_DEPTH)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  reset           in   1   asynchronous, active-high reset
//  imem_req        out  1   read request valid
//  imem_addr       out  32  word-aligned fetch address (bits[1:0]=00)
//  imem_gnt        in   1   request accepted this cycle (req&gnt = transfer)
//  imem_rvalid     in   1   read data valid; responses in request order, >=1 cycle after grant
//  imem_rdata      in   32  instruction word
//  redirect_valid  in   1   taken branch/jump: restart fetch at redirect_pc
//  redirect_pc     in   32  new PC; bits[1:0] ignored (forced 00)
//  inst_valid      out  1   FIFO head valid
//  inst_data       out  32  FIFO head instruction
//  inst_pc         out  32  PC of FIFO head
//  inst_ready      in   1   datapath consumes head (valid&ready = pop)
// BEHAVIOUR
//  Reset (async, immediate): fetch_pc=RESET_PC, FIFO empty, outst=0, drop=0; imem_req=0,
//   imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0. First req the cycle after deassert.
//  Issue: imem_req=1 iff !redirect_valid && outst<MAX_OUTST && (fifo_cnt+outst-drop)<FIFO_DEPTH
//   (credit scheme: every non-dropped response has a guaranteed slot, FIFO never overflows).
//   imem_addr=fetch_pc held stable while req&!gnt. On grant: fetch_pc+=4 (mod 2^32, FFFFFFFC->0),
//   outst+=1. Back-to-back grants allowed (one per cycle).
//  Response: rvalid decrements outst. If drop>0: data discarded, drop-=1. Else push
//   {pc_of_request, rdata}; PC tracked by a resp_pc register advancing +4 per kept response.
//  Output: inst_* driven from FIFO head (registered storage, combinational read of head).
//   Fetch-to-inst_valid latency = imem latency + 1 cycle (push then visible). Pop on valid&ready.
//   Simultaneous push and pop on full FIFO is legal; count unchanged.
//  Redirect (redirect_valid=1 in cycle T): at edge T: FIFO emptied (inst_valid=0 in T+1), any pop in T
//   ignored, fetch_pc<=redirect_pc&~3, resp_pc<=same, drop<=drop+outst(+grant in T is impossible:
//   req forced 0) minus 1 if a response arrives in T that would itself be dropped/discarded.
//   A response arriving in T is always discarded. First new req in T+1. Back-to-back redirects:
//   last wins, drop accumulates correctly.
//  outst and drop saturate logically at MAX_OUTST; drop<=outst always (assertion).
//  No exceptions, no misaligned-fetch trap; imem errors not modelled.
// STRUCTURE
//  Shared package mips_pkg: INST_W=32, PC_INC=4, RESET_PC_DEFAULT, NOP_INST=32'h0000_0000.
//  One sub-module: mips_fetch_fifo (sync FIFO, DEPTH, WIDTH=64 {pc,inst}, push/pop/flush,
//   count, full/empty; flush has priority over push and pop). Top holds PC, outst/drop
//   counters, issue logic.
// TESTING
//  1 Reset: assert reset mid-run with 3 entries buffered -> all outputs to reset values same
//    cycle; after release first imem_addr=0x0000_0000.
//  2 Streaming: imem gnt=1, 1-cycle rvalid, ready=1 -> addrs 0,4,8,...; inst_pc tracks, one
//    instruction per cycle sustained, inst_data equals memory words in order.
//  3 Backpressure: ready=0 -> exactly FIFO_DEPTH(4) entries buffered, imem_req drops to 0, no loss;
//    ready=1 resumes with PC 0x10 next.
//  4 Redirect with 2 in flight: redirect_pc=0x0000_0103 -> next req addr 0x100, both stale
//    responses discarded, first inst_pc=0x100, inst_valid=0 cycle after redirect.
//  5 Wrap/stall: fetch_pc 0xFFFF_FFFC with gnt=0 for 3 cycles -> addr held; after grant next
//    addr 0x0000_0000.
//  6 Redirect same cycle as rvalid and pop -> response dropped, pop ignored, drop count ends 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the mips_32 instruction-fetch front end.
package mips_pkg;
   localparam int          INST_W           = 32;
   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0000;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/mips_fetch_fifo.sv
// In-order prefetch FIFO holding {pc, inst} entries; flush beats push and pop.
module mips_fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [WIDTH-1:0]       data_i,
   output logic [WIDTH-1:0]       data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign do_pop  = pop_i && !empty_o;
   // A push into a full FIFO is fine when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // NOTE: storage carries no reset; an entry is only read after it was written,
   // and the top masks the head while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch front end: owns the PC, issues credit-limited imem reads, buffers responses.
module mips_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 4,
   parameter int          MAX_OUTST  = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);
   localparam int CW  = $clog2(MAX_OUTST + 1);
   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
   logic [CW-1:0] outst_q, outst_d, drop_q, drop_d;
   logic [FCW-1:0] fifo_cnt;
   logic [FCW:0]   committed;
   logic           fifo_full, fifo_empty, grant, push, pop;
   fetch_entry_t   push_entry, head;

   // Slots already spoken for: buffered entries plus responses that will be kept.
   assign committed = {1'b0, fifo_cnt} + (FCW+1)'(outst_q) - (FCW+1)'(drop_q);
   assign imem_req  = !reset && !redirect_valid && (outst_q < CW'(MAX_OUTST))
                      && (committed < (FCW+1)'(FIFO_DEPTH));
   assign imem_addr = fetch_pc_q;
   assign grant     = imem_req && imem_gnt;
   assign push      = imem_rvalid && (drop_q == '0) && !redirect_valid;
   assign pop       = inst_valid && inst_ready && !redirect_valid;

   assign inst_valid = !fifo_empty;
   assign inst_data  = inst_valid ? head.inst : NOP_INST;
   assign inst_pc    = inst_valid ? head.pc   : 32'h0;

   // NOTE: every variable gets a default first, so no path can infer a latch.
   always_comb begin
      fetch_pc_d      = fetch_pc_q;
      resp_pc_d       = resp_pc_q;
      drop_d          = drop_q;
      outst_d         = outst_q + CW'(grant) - CW'(imem_rvalid);
      push_entry.pc   = resp_pc_q;
      push_entry.inst = imem_rdata;
      if (grant) fetch_pc_d = fetch_pc_q + PC_INC;
      if (imem_rvalid) begin
         if (drop_q != '0) drop_d = drop_q - CW'(1);
         else              resp_pc_d = resp_pc_q + PC_INC;
      end
      // On redirect everything still in flight afterwards is stale.
      if (redirect_valid) begin
         fetch_pc_d = word_align(redirect_pc);
         resp_pc_d  = word_align(redirect_pc);
         drop_d     = outst_d;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

   mips_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .data_i  (push_entry),
      .data_o  (head),
      .count_o (fifo_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   a_drop_le_outst: assert property (@(posedge clk) disable iff (reset) drop_q <= outst_q);
   a_rsp_expected:  assert property (@(posedge clk) disable iff (reset) imem_rvalid |-> outst_q != '0);
   a_no_overflow:   assert property (@(posedge clk) disable iff (reset) push |-> (!fifo_full || pop));
endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with an in-order imem responder model.
module tb_mips_fetch_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid, inst_ready = 1'b0;
   logic [31:0] inst_data, inst_pc;
   bit          rsp_en = 1'b1;
   int          n_cmp = 0, n_bad = 0;
   logic [31:0] pend [$];

   always #5 clk = ~clk;

   mips_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4), .MAX_OUTST(2)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
      .inst_ready(inst_ready)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Responses leave in grant order, one per cycle while rsp_en is set.
   always @(posedge clk) begin : imem_model
      bit g, r;
      logic [31:0] a;
      g = imem_req && imem_gnt;
      r = imem_rvalid;
      a = imem_addr;
      #1;
      if (reset) begin
         pend.delete();
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end else begin
         if (r && pend.size() > 0) void'(pend.pop_front());
         if (g) pend.push_back(a);
         imem_rvalid = rsp_en && (pend.size() > 0);
         imem_rdata  = imem_rvalid ? mem_word(pend[0]) : 32'h0;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      next_cycle();
      reset = 1'b1; redirect_valid = 1'b0; imem_gnt = 1'b0; inst_ready = 1'b0; rsp_en = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp += 5;
      if (imem_req !== 1'b0)   begin n_bad++; $display("FAIL por_req: got %b want 0", imem_req); end
      if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL por_addr: got %h want 0", imem_addr); end
      if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL por_valid: got %b want 0", inst_valid); end
      if (inst_data !== 32'h0) begin n_bad++; $display("FAIL por_data: got %h want 0", inst_data); end
      if (inst_pc !== 32'h0)   begin n_bad++; $display("FAIL por_pc: got %h want 0", inst_pc); end
      do_reset();
      imem_gnt = 1'b1;
      @(negedge clk);
      n_cmp += 2;
      if (imem_req !== 1'b1)   begin n_bad++; $display("FAIL rel_req: got %b want 1", imem_req); end
      if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rel_addr: got %h want 0", imem_addr); end
      repeat (4) next_cycle();
      @(negedge clk);
      n_cmp += 2;
      if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL pre_valid: got %b want 1", inst_valid); end
      if (imem_req !== 1'b0)   begin n_bad++; $display("FAIL pre_req: got %b want 0", imem_req); end
      reset = 1'b1;
      #1;
      n_cmp += 5;
      if (imem_req !== 1'b0)   begin n_bad++; $display("FAIL mid_req: got %b want 0", imem_req); end
      if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL mid_addr: got %h want 0", imem_addr); end
      if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", inst_valid); end
      if (inst_data !== 32'h0) begin n_bad++; $display("FAIL mid_data: got %h want 0", inst_data); end
      if (inst_pc !== 32'h0)   begin n_bad++; $display("FAIL mid_pc: got %h want 0", inst_pc); end
      next_cycle();
      reset = 1'b0; inst_ready = 1'b1;
      @(negedge clk);
      n_cmp += 2;
      if (imem_addr !== 32'h0 || imem_req !== 1'b1)
         begin n_bad++; $display("FAIL post_req: got %b/%h want 1/0", imem_req, imem_addr); end
      if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL post_valid: got %b want 0", inst_valid); end
      repeat (2) next_cycle();
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== mem_word(32'h0))
         begin n_bad++; $display("FAIL post_inst: got %b/%h/%h want 1/0/%h", inst_valid, inst_pc, inst_data, mem_word(32'h0)); end
   endtask

   task automatic test_streaming();
      do_reset();
      imem_gnt = 1'b1; inst_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         logic [31:0] epc;
         if (k > 0) next_cycle();
         @(negedge clk);
         epc = 32'(4 * (k - 2));
         n_cmp += 2;
         if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k))
            begin n_bad++; $display("FAIL stream_req[%0d]: got %b/%h want 1/%h", k, imem_req, imem_addr, 32'(4 * k)); end
         if (k < 2) begin
            if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want 0", k, inst_valid); end
         end else if (inst_valid !== 1'b1 || inst_pc !== epc || inst_data !== mem_word(epc)) begin
            n_bad++;
            $display("FAIL stream_inst[%0d]: got %b/%h/%h want 1/%h/%h", k, inst_valid, inst_pc, inst_data, epc, mem_word(epc));
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      imem_gnt = 1'b1;
      for (int k = 0; k < 14; k++) begin
         logic        ereq;
         logic [31:0] eaddr, epc;
         if (k > 0) next_cycle();
         if (k == 8) inst_ready = 1'b1;
         @(negedge clk);
         ereq  = (k <= 3) || (k >= 9);
         eaddr = (k <= 3) ? 32'(4 * k) : (k <= 9) ? 32'h10 : 32'(32'h10 + 4 * (k - 9));
         epc   = (k < 8) ? 32'h0 : 32'(4 * (k - 8));
         n_cmp += 2;
         if (imem_req !== ereq || imem_addr !== eaddr)
            begin n_bad++; $display("FAIL bp_req[%0d]: got %b/%h want %b/%h", k, imem_req, imem_addr, ereq, eaddr); end
         if (k < 2) begin
            if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 0", k, inst_valid); end
         end else if (inst_valid !== 1'b1 || inst_pc !== epc || inst_data !== mem_word(epc)) begin
            n_bad++;
            $display("FAIL bp_inst[%0d]: got %b/%h/%h want 1/%h/%h", k, inst_valid, inst_pc, inst_data, epc, mem_word(epc));
         end
      end
   endtask

   task automatic test_redirect();
      do_reset();
      imem_gnt = 1'b1;
      next_cycle();
      rsp_en = 1'b0;
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8)
         begin n_bad++; $display("FAIL rd_pre_req: got %b/%h want 1/00000008", imem_req, imem_addr); end
      next_cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; rsp_en = 1'b1;
      @(negedge clk);
      n_cmp += 2;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0)
         begin n_bad++; $display("FAIL rd_pre_inst: got %b/%h want 1/0", inst_valid, inst_pc); end
      if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rd_req_forced: got %b want 0", imem_req); end
      next_cycle();
      redirect_valid = 1'b0; inst_ready = 1'b1;
      @(negedge clk);
      n_cmp += 2;
      if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rd_flush: got %b want 0", inst_valid); end
      if (imem_req !== 1'b0 || imem_addr !== 32'h100)
         begin n_bad++; $display("FAIL rd_full_outst: got %b/%h want 0/00000100", imem_req, imem_addr); end
      next_cycle();
      @(negedge clk);
      n_cmp += 2;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100)
         begin n_bad++; $display("FAIL rd_new_req: got %b/%h want 1/00000100", imem_req, imem_addr); end
      if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rd_stale1: got %b want 0", inst_valid); end
      next_cycle();
      @(negedge clk);
      n_cmp += 2;
      if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rd_stale2: got %b want 0", inst_valid); end
      if (imem_addr !== 32'h104) begin n_bad++; $display("FAIL rd_addr2: got %h want 00000104", imem_addr); end
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== mem_word(32'h100))
         begin n_bad++; $display("FAIL rd_first: got %b/%h/%h want 1/00000100/%h", inst_valid, inst_pc, inst_data, mem_word(32'h100)); end
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h104)
         begin n_bad++; $display("FAIL rd_second: got %b/%h want 1/00000104", inst_valid, inst_pc); end
   endtask

   task automatic test_wrap_stall();
      do_reset();
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b0) begin n_bad++; $display("FAIL wr_req_forced: got %b want 0", imem_req); end
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         redirect_valid = 1'b0;
         if (k == 4) imem_gnt = 1'b1;
         @(negedge clk);
         n_cmp++;
         if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC)
            begin n_bad++; $display("FAIL wr_hold[%0d]: got %b/%h want 1/fffffffc", k, imem_req, imem_addr); end
      end
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0)
         begin n_bad++; $display("FAIL wr_wrap: got %b/%h want 1/00000000", imem_req, imem_addr); end
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_data !== mem_word(32'hFFFF_FFFC))
         begin n_bad++; $display("FAIL wr_inst_top: got %b/%h/%h want 1/fffffffc/%h", inst_valid, inst_pc, inst_data, mem_word(32'hFFFF_FFFC)); end
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== mem_word(32'h0))
         begin n_bad++; $display("FAIL wr_inst_zero: got %b/%h/%h want 1/0/%h", inst_valid, inst_pc, inst_data, mem_word(32'h0)); end
   endtask

   task automatic test_redirect_rvalid_pop();
      do_reset();
      imem_gnt = 1'b1; inst_ready = 1'b1;
      repeat (2) next_cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      @(negedge clk);
      n_cmp += 2;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0)
         begin n_bad++; $display("FAIL rrp_pre_inst: got %b/%h want 1/0", inst_valid, inst_pc); end
      if (imem_rvalid !== 1'b1 || imem_req !== 1'b0)
         begin n_bad++; $display("FAIL rrp_pre_bus: got rvalid %b req %b want 1/0", imem_rvalid, imem_req); end
      next_cycle();
      redirect_valid = 1'b0;
      @(negedge clk);
      n_cmp += 2;
      if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rrp_flush: got %b want 0", inst_valid); end
      if (imem_req !== 1'b1 || imem_addr !== 32'h200)
         begin n_bad++; $display("FAIL rrp_req: got %b/%h want 1/00000200", imem_req, imem_addr); end
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h204)
         begin n_bad++; $display("FAIL rrp_req2: got %b/%h want 1/00000204", imem_req, imem_addr); end
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst_data !== mem_word(32'h200))
         begin n_bad++; $display("FAIL rrp_kept: got %b/%h/%h want 1/00000200/%h", inst_valid, inst_pc, inst_data, mem_word(32'h200)); end
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h204)
         begin n_bad++; $display("FAIL rrp_next: got %b/%h want 1/00000204", inst_valid, inst_pc); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect();
      test_wrap_stall();
      test_redirect_rvalid_pop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end
endmodule
